// File: rtl/axis_adc_boxcar_decimator.sv
// Two-channel boxcar integrate-and-dump decimator for the packed ADC AXI4-Stream.
// Optional macro DECIM_SATURATE_EN clamps each scaled channel to signed 16 bits instead of wrapping.
module axis_adc_boxcar_decimator #(
   parameter int CNTR_WIDTH = 16
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [CNTR_WIDTH-1:0] cfg_ratio,
   input  logic [4:0]            cfg_shift,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tvalid,
   input  logic [31:0]           s_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [31:0]           m_axis_tdata,
   output logic                  overrun
);
   localparam int SW = 16 + CNTR_WIDTH;
   localparam logic [CNTR_WIDTH-1:0] ONE = CNTR_WIDTH'(1);

   logic [CNTR_WIDTH-1:0] cnt_q, cnt_d, rl_q, rl_d, rl_eff;
   logic signed [SW-1:0]  acc_a_q, acc_a_d, acc_b_q, acc_b_d;
   logic signed [SW-1:0]  sum_a, sum_b;
   logic                  m_tvalid_q, m_tvalid_d, overrun_q, overrun_d;
   logic [31:0]           m_tdata_q, m_tdata_d;
   logic [15:0]           out_a, out_b;
   logic                  dump;

   assign s_axis_tready = 1'b1;
   assign m_axis_tvalid = m_tvalid_q;
   assign m_axis_tdata  = m_tdata_q;
   assign overrun       = overrun_q;

   // The ratio is only picked up at the first beat of a block, so mid-block edits wait a block.
   assign rl_eff = (cnt_q == '0) ? ((cfg_ratio == '0) ? ONE : cfg_ratio) : rl_q;
   assign dump   = s_axis_tvalid && (cnt_q == rl_eff - ONE);

   assign sum_a = acc_a_q + {{CNTR_WIDTH{s_axis_tdata[15]}}, s_axis_tdata[15:0]};
   assign sum_b = acc_b_q + {{CNTR_WIDTH{s_axis_tdata[31]}}, s_axis_tdata[31:16]};

`ifdef DECIM_SATURATE_EN
   localparam logic signed [SW-1:0] SAT_MAX = 32767;
   localparam logic signed [SW-1:0] SAT_MIN = -32768;
   logic signed [SW-1:0] y_a, y_b;

   assign y_a   = sum_a >>> cfg_shift;
   assign y_b   = sum_b >>> cfg_shift;
   assign out_a = (y_a > SAT_MAX) ? 16'h7FFF : (y_a < SAT_MIN) ? 16'h8000 : y_a[15:0];
   assign out_b = (y_b > SAT_MAX) ? 16'h7FFF : (y_b < SAT_MIN) ? 16'h8000 : y_b[15:0];
`else
   assign out_a = 16'(sum_a >>> cfg_shift);
   assign out_b = 16'(sum_b >>> cfg_shift);
`endif

   always_comb begin
      cnt_d      = cnt_q;
      rl_d       = rl_q;
      acc_a_d    = acc_a_q;
      acc_b_d    = acc_b_q;
      m_tvalid_d = m_tvalid_q;
      m_tdata_d  = m_tdata_q;
      overrun_d  = overrun_q;

      if (s_axis_tvalid) begin
         if (cnt_q == '0) rl_d = rl_eff;
         if (dump) begin
            cnt_d   = '0;
            acc_a_d = '0;
            acc_b_d = '0;
         end else begin
            cnt_d   = cnt_q + ONE;
            acc_a_d = sum_a;
            acc_b_d = sum_b;
         end
      end

      // A dump into a stalled, still-occupied output register is lost rather than stalling the ADC.
      if (dump) begin
         if (!m_tvalid_q || m_axis_tready) begin
            m_tdata_d  = {out_b, out_a};
            m_tvalid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (m_tvalid_q && m_axis_tready) begin
         m_tvalid_d = 1'b0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt_q      <= '0;
         rl_q       <= ONE;
         acc_a_q    <= '0;
         acc_b_q    <= '0;
         m_tvalid_q <= 1'b0;
         m_tdata_q  <= '0;
         overrun_q  <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         rl_q       <= rl_d;
         acc_a_q    <= acc_a_d;
         acc_b_q    <= acc_b_d;
         m_tvalid_q <= m_tvalid_d;
         m_tdata_q  <= m_tdata_d;
         overrun_q  <= overrun_d;
      end
   end
endmodule

// File: tb/tb_axis_adc_boxcar_decimator.sv
// Bench for axis_adc_boxcar_decimator: directed literal cases plus randomized traffic against a block-sum model.
// Build with DECIM_SATURATE_EN defined or not; the model follows the same macro.
module tb_axis_adc_boxcar_decimator;
   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [15:0] cfg_ratio = 16'd1;
   logic [4:0]  cfg_shift = 5'd0;
   logic        s_axis_tready;
   logic        s_axis_tvalid = 1'b0;
   logic [31:0] s_axis_tdata = 32'd0;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic [31:0] m_axis_tdata;
   logic        overrun;

   int checks = 0;
   int failures = 0;

   axis_adc_boxcar_decimator #(.CNTR_WIDTH(16)) dut (
      .aclk(aclk), .aresetn(aresetn), .cfg_ratio(cfg_ratio), .cfg_shift(cfg_shift),
      .s_axis_tready(s_axis_tready), .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
      .overrun(overrun)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h at t=%0t", name, got, exp, $time);
      end
   endtask

   // Reference model: block of Rl samples summed as plain integers.
   int          m_cnt = 0;
   int          m_rl = 1;
   longint      m_sa = 0;
   longint      m_sb = 0;
   logic        m_v = 1'b0;
   logic [31:0] m_d = 32'd0;
   logic        m_ovr = 1'b0;

   function automatic logic [15:0] reduce16(input longint y);
`ifdef DECIM_SATURATE_EN
      if (y > 32767) return 16'h7FFF;
      if (y < -32768) return 16'h8000;
`endif
      return y[15:0];
   endfunction

   always @(posedge aclk) begin
      if (!aresetn) begin
         m_cnt = 0; m_rl = 1; m_sa = 0; m_sb = 0; m_v = 1'b0; m_d = 32'd0; m_ovr = 1'b0;
      end else begin
         logic        do_dump;
         logic [31:0] word;
         do_dump = 1'b0;
         word = 32'd0;
         if (s_axis_tvalid) begin
            if (m_cnt == 0) m_rl = (cfg_ratio == 0) ? 1 : int'(cfg_ratio);
            m_sa += longint'($signed(s_axis_tdata[15:0]));
            m_sb += longint'($signed(s_axis_tdata[31:16]));
            m_cnt++;
            if (m_cnt == m_rl) begin
               do_dump = 1'b1;
               word = {reduce16(m_sb >>> cfg_shift), reduce16(m_sa >>> cfg_shift)};
               m_sa = 0; m_sb = 0; m_cnt = 0;
            end
         end
         if (do_dump) begin
            if (!m_v || m_axis_tready) begin m_d = word; m_v = 1'b1; end
            else m_ovr = 1'b1;
         end else if (m_v && m_axis_tready) begin
            m_v = 1'b0;
         end
      end
   end

   always @(negedge aclk) begin
      if (aresetn) begin
         chk("model_tvalid", {31'd0, m_axis_tvalid}, {31'd0, m_v});
         chk("model_overrun", {31'd0, overrun}, {31'd0, m_ovr});
         chk("tready_const", {31'd0, s_axis_tready}, 32'd1);
         if (m_v) chk("model_tdata", m_axis_tdata, m_d);
      end
   end

   task automatic beat(input logic [15:0] a, input logic [15:0] b);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {b, a};
   endtask

   initial begin
      logic [31:0] sat_exp;
      repeat (3) @(negedge aclk);
      chk("reset_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      chk("reset_tdata", m_axis_tdata, 32'd0);
      chk("reset_overrun", {31'd0, overrun}, 32'd0);
      chk("reset_tready", {31'd0, s_axis_tready}, 32'd1);
      aresetn = 1'b1;

      // Basic decimation: R=4, shift=2.
      cfg_ratio = 16'd4; cfg_shift = 5'd2; m_axis_tready = 1'b1;
      for (int i = 0; i <= 12; i++) begin
         @(negedge aclk);
         if (i > 0) chk("basic_tvalid", {31'd0, m_axis_tvalid}, {31'd0, (i % 4) == 0});
         if (i > 0 && (i % 4) == 0) chk("basic_tdata", m_axis_tdata, 32'hFF38_0064);
         if (i < 12) beat(16'd100, 16'hFF38); else s_axis_tvalid = 1'b0;
      end

      // Pass-through: R=0 acts as 1.
      cfg_ratio = 16'd0; cfg_shift = 5'd0;
      for (int i = 0; i <= 6; i++) begin
         @(negedge aclk);
         if (i > 0) begin
            chk("pass_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
            chk("pass_tdata", m_axis_tdata, 32'h8000_1234);
         end
         if (i < 6) beat(16'h1234, 16'h8000); else s_axis_tvalid = 1'b0;
      end
      repeat (2) @(negedge aclk);

      // Saturation / wrap.
`ifdef DECIM_SATURATE_EN
      sat_exp = 32'h8000_7FFF;
`else
      sat_exp = 32'h2B40_D4C0;
`endif
      cfg_ratio = 16'd4; cfg_shift = 5'd0;
      for (int i = 0; i <= 4; i++) begin
         @(negedge aclk);
         if (i == 4) begin
            chk("sat_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
            chk("sat_tdata", m_axis_tdata, sat_exp);
         end
         if (i < 4) beat(16'd30000, 16'(-30000)); else s_axis_tvalid = 1'b0;
      end
      repeat (2) @(negedge aclk);

      // Backpressure: first word held, second dropped, overrun sticky.
      cfg_ratio = 16'd2;
      for (int i = 0; i <= 5; i++) begin
         @(negedge aclk);
         if (i == 2) begin
            chk("bp_first_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
            chk("bp_first_tdata", m_axis_tdata, 32'hFFFD_0003);
            chk("bp_no_overrun_yet", {31'd0, overrun}, 32'd0);
         end
         if (i == 4) begin
            chk("bp_held_tdata", m_axis_tdata, 32'hFFFD_0003);
            chk("bp_overrun", {31'd0, overrun}, 32'd1);
         end
         if (i == 5) begin
            chk("bp_tvalid_fall", {31'd0, m_axis_tvalid}, 32'd0);
            chk("bp_overrun_sticky", {31'd0, overrun}, 32'd1);
         end
         if (i < 4) begin
            m_axis_tready = 1'b0;
            beat(16'(i + 1), 16'(-(i + 1)));
         end else begin
            s_axis_tvalid = 1'b0;
            m_axis_tready = 1'b1;
         end
      end

      // Reset mid-block.
      cfg_ratio = 16'd4; cfg_shift = 5'd0;
      @(negedge aclk); beat(16'd1000, 16'd1000);
      @(negedge aclk); beat(16'd1000, 16'd1000);
      @(negedge aclk);
      s_axis_tvalid = 1'b0;
      aresetn = 1'b0;
      #1;
      chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      chk("rst_tdata", m_axis_tdata, 32'd0);
      chk("rst_overrun", {31'd0, overrun}, 32'd0);
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      for (int i = 0; i <= 4; i++) begin
         @(negedge aclk);
         if (i > 0) chk("rst_after_tvalid", {31'd0, m_axis_tvalid}, {31'd0, i == 4});
         if (i == 4) chk("rst_after_tdata", m_axis_tdata, 32'hFFEC_0014);
         if (i < 4) beat(16'd5, 16'(-5)); else s_axis_tvalid = 1'b0;
      end
      repeat (2) @(negedge aclk);

      // Ratio change mid-block.
      cfg_ratio = 16'd4;
      for (int i = 0; i <= 8; i++) begin
         @(negedge aclk);
         if (i == 2) cfg_ratio = 16'd2;
         if (i > 0) chk("ratio_tvalid", {31'd0, m_axis_tvalid}, {31'd0, (i == 4) || (i == 6) || (i == 8)});
         if (i == 4) chk("ratio_first_tdata", m_axis_tdata, 32'h0004_0004);
         if (i == 6 || i == 8) chk("ratio_next_tdata", m_axis_tdata, 32'h0002_0002);
         if (i < 8) beat(16'd1, 16'd1); else s_axis_tvalid = 1'b0;
      end
      repeat (2) @(negedge aclk);

      // Randomized traffic, checked every cycle by the model.
      for (int i = 0; i < 4000; i++) begin
         @(negedge aclk);
         if ($urandom_range(0, 19) == 0) cfg_ratio = 16'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) cfg_shift = 5'($urandom_range(0, 31));
         m_axis_tready = ($urandom_range(0, 3) != 0);
         s_axis_tvalid = ($urandom_range(0, 3) != 0);
         s_axis_tdata  = $urandom();
         if ($urandom_range(0, 799) == 0) begin
            aresetn = 1'b0;
            #1;
            chk("rand_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
            chk("rand_rst_overrun", {31'd0, overrun}, 32'd0);
            @(negedge aclk);
            aresetn = 1'b1;
         end
      end
      @(negedge aclk);
      s_axis_tvalid = 1'b0;
      repeat (3) @(negedge aclk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
